// File: rtl/addsub_pkg.sv
// Shared types and elaboration-time checks for the digit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand width splits evenly into whole digits.
  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 32'sd1) && (digit <= width) && ((width % digit) == 32'sd0);
  endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// One DIGIT-bit add/subtract slice; the serial top reuses a single copy for every digit.
module digit_addsub
  import addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             sub,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);

  logic [DIGIT:0] sum_s;

  // Subtraction is addition of the inverted subtrahend with an inverted incoming borrow.
  always_comb begin
    sum_s = {1'b0, a_d} + {1'b0, b_d ^ {DIGIT{sub}}} + {{DIGIT{1'b0}}, c_in};
  end

  assign s_d   = sum_s[DIGIT-1:0];
  assign c_out = sum_s[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: accepts one operand set, walks it LSB digit first
// through a shared slice, then holds the result and flags until the consumer takes them.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode_sub,
  input  logic             cb_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 32'sd1) ? $clog2(NDIG) : 32'sd1;
  localparam int IW   = (WIDTH > 32'sd1) ? $clog2(WIDTH) : 32'sd1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 32'sd1);
  localparam logic [CW-1:0] ONE  = CW'(32'sd1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $fatal(1, "serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             c_r;
  logic [WIDTH-1:0] result_r;
  logic             cb_out_r;
  logic             ovf_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [DIGIT-1:0] sum_d_s;
  logic             c_out_s;
  logic [IW-1:0]    base_s;
  logic [WIDTH-1:0] result_next_s;

  // Operands shift right each digit, so the active digit always sits in the low bits.
  digit_addsub #(.DIGIT(DIGIT)) u_slice (
    .a_d   (a_r[DIGIT-1:0]),
    .b_d   (b_r[DIGIT-1:0]),
    .sub   (sub_r),
    .c_in  (c_r),
    .s_d   (sum_d_s),
    .c_out (c_out_s)
  );

  assign base_s = IW'(cnt_r * DIGIT);

  // Result image with the current digit merged in, used for the write and the zero flag.
  always_comb begin
    result_next_s = result_r;
    result_next_s[base_s +: DIGIT] = sum_d_s;
  end

  // Control FSM with operand, digit and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sub_r       <= 1'b0;
      c_r         <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      cb_out_r    <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            sub_r      <= mode_sub;
            c_r        <= cb_in ^ mode_sub;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          result_r <= result_next_s;
          c_r      <= c_out_s;
          a_r      <= a_r >> DIGIT;
          b_r      <= b_r >> DIGIT;
          cnt_r    <= cnt_r + ONE;
          // On the last digit the low slice bits hold the operand MSBs.
          if (cnt_r == LAST) begin
            cb_out_r    <= c_out_s ^ sub_r;
            ovf_r       <= (a_r[DIGIT-1] == (b_r[DIGIT-1] ^ sub_r)) &&
                           (sum_d_s[DIGIT-1] != a_r[DIGIT-1]);
            zero_r      <= (result_next_s == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cb_out    = cb_out_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (DIGIT 4, 1, 16) share stimulus; an arithmetic
// model scores every valid result cycle, and directed cases pin literal expectations.
module tb_serial_addsub;

  typedef struct packed {
    logic [15:0] res;
    logic        cb;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        mode_sub;
  logic        cb_in;
  logic        out_ready;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [15:0] result_w    [3];
  logic        cb_out_w    [3];
  logic        ovf_w       [3];
  logic        zero_w      [3];

  int   total;
  int   bad;
  int   cyc;
  exp_t ring [3][4];
  int   wp [3];
  int   rp [3];
  bit   seen [3];
  int   done_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_addsub #(.WIDTH(16), .DIGIT(g == 0 ? 4 : (g == 1 ? 1 : 16))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a_in),
      .b         (b_in),
      .mode_sub  (mode_sub),
      .cb_in     (cb_in),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .result    (result_w[g]),
      .cb_out    (cb_out_w[g]),
      .ovf       (ovf_w[g]),
      .zero      (zero_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ndig_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 16 : 1);
  endfunction

  // Result defined by plain integer arithmetic, signed range for overflow.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input logic c, input int acc);
    exp_t r;
    int ux, uy, sx, sy, full, sv, ci;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (s) begin
      full = ux - uy - ci;
      sv   = sx - sy - ci;
      r.cb = (ux < uy + ci);
    end else begin
      full = ux + uy + ci;
      sv   = sx + sy + ci;
      r.cb = (full > 65535);
    end
    r.res  = full[15:0];
    r.ovf  = (sv > 32767) || (sv < -32768);
    r.zero = (r.res == 16'h0000);
    r.acc  = acc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic wait_all_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      idle = in_ready_w[0] && in_ready_w[1] && in_ready_w[2] &&
             !out_valid_w[0] && !out_valid_w[1] && !out_valid_w[2];
      if (!idle) tick();
    end
    check("idle_wait", 32'(idle), 32'd1);
  endtask

  // Directed operation on all instances; literal expectations apply to the DIGIT=4 unit.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic c, input logic [15:0] er, input logic ecb,
                        input logic eovf, input logic ezero, input string name);
    int n;
    wait_all_idle();
    out_ready = 1'b0;
    a_in = x; b_in = y; mode_sub = s; cb_in = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom); mode_sub = ~s; cb_in = ~c;
    n = 0;
    while (!out_valid_w[0] && n < 40) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd4);
    check({name, "_result"}, {16'd0, result_w[0]}, {16'd0, er});
    check({name, "_flags"}, {29'd0, cb_out_w[0], ovf_w[0], zero_w[0]}, {29'd0, ecb, eovf, ezero});
    out_ready = 1'b1;
  endtask

  initial begin
    int acc_at [$];
    total = 0; bad = 0; cyc = 0;
    for (int g = 0; g < 3; g++) begin
      wp[g] = 0; rp[g] = 0; seen[g] = 1'b0; done_cnt[g] = 0;
    end
    rst = 1'b1; in_valid = 1'b0; a_in = 16'h0000; b_in = 16'h0000;
    mode_sub = 1'b0; cb_in = 1'b0; out_ready = 1'b1;

    // Scoreboard: record accepts per instance and check every cycle a result is valid.
    fork
      forever begin
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 3; g++) begin
          if (rst) begin
            rp[g] = wp[g];
            seen[g] = 1'b0;
          end else begin
            if (out_valid_w[g]) begin
              check($sformatf("pending_%0d", g), 32'(rp[g] != wp[g]), 32'd1);
              if (rp[g] != wp[g]) begin
                exp_t e;
                e = ring[g][rp[g] % 4];
                if (!seen[g]) begin
                  seen[g] = 1'b1;
                  check($sformatf("model_latency_%0d", g), 32'(cyc - e.acc), 32'(ndig_of(g) + 1));
                end
                check($sformatf("model_out_%0d", g),
                      {13'd0, result_w[g], cb_out_w[g], ovf_w[g], zero_w[g]},
                      {13'd0, e.res, e.cb, e.ovf, e.zero});
                check($sformatf("ready_low_%0d", g), 32'(in_ready_w[g]), 32'd0);
                if (out_ready) begin
                  rp[g]++;
                  seen[g] = 1'b0;
                  done_cnt[g]++;
                end
              end
            end
            if (in_valid && in_ready_w[g]) begin
              ring[g][wp[g] % 4] = model(a_in, b_in, mode_sub, cb_in, cyc);
              wp[g]++;
            end
          end
        end
      end
    join_none

    tick();
    check("reset_state", {26'd0, in_ready_w[0], out_valid_w[0], cb_out_w[0], ovf_w[0], zero_w[0], 1'b0},
          {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_result", {16'd0, result_w[0]}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(16'h1234, 16'h0235, 1'b1, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, "sub_basic");
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "sub_wrap");
    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, "sub_borrow_in");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, "sub_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_carry");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");

    // Backpressure: result held, new operands ignored, ready returns after the drain edge.
    wait_all_idle();
    out_ready = 1'b0;
    a_in = 16'h1234; b_in = 16'h0235; mode_sub = 1'b1; cb_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 40 && !out_valid_w[0]; n++) tick();
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      tick();
      check("bp_result", {16'd0, result_w[0]}, 32'h0000_0FFF);
      check("bp_hold", {30'd0, out_valid_w[0], in_ready_w[0]}, {30'd0, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, out_valid_w[0], in_ready_w[0]}, {30'd0, 1'b0, 1'b1});

    // Asynchronous reset during RUN, then a fresh operation.
    wait_all_idle();
    a_in = 16'h1234; b_in = 16'h0235; mode_sub = 1'b1; cb_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("async_rst_ctl", {30'd0, out_valid_w[0], in_ready_w[0]}, {30'd0, 1'b0, 1'b1});
    check("async_rst_out", {13'd0, result_w[0], cb_out_w[0], ovf_w[0], zero_w[0]}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op(16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "after_rst");

    // Back-to-back: in_valid held high, accepts every NDIG+2 cycles.
    wait_all_idle();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (in_ready_w[0]) acc_at.push_back(i);
      a_in = pick(); b_in = pick(); mode_sub = 1'($urandom); cb_in = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(acc_at.size() >= 4), 32'd1);
    for (int i = 1; i < acc_at.size(); i++)
      check("b2b_spacing", 32'(acc_at[i] - acc_at[i-1]), 32'd6);

    // Random traffic with random backpressure.
    wait_all_idle();
    for (int g = 0; g < 3; g++) done_cnt[g] = 0;
    for (int i = 0; i < 12000; i++) begin
      in_valid  = 1'($urandom);
      a_in      = pick();
      b_in      = pick();
      mode_sub  = 1'($urandom);
      cb_in     = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_all_idle();
    tick();
    for (int g = 0; g < 3; g++)
      check($sformatf("drained_%0d", g), 32'(rp[g] == wp[g]), 32'd1);
    check("random_volume", 32'(done_cnt[0] > 1000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
